// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster RGB888 stream to 3x3 window for the convolution stage.
// Optional WIN_COORD_EN adds o_row/o_col centre-pixel coordinates.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [23:0] i_pixel,
  input  logic        i_valid,
  input  logic        i_sof,
  output logic [23:0] o_p1,
  output logic [23:0] o_p2,
  output logic [23:0] o_p3,
  output logic [23:0] o_p4,
  output logic [23:0] o_p5,
  output logic [23:0] o_p6,
  output logic [23:0] o_p7,
  output logic [23:0] o_p8,
  output logic [23:0] o_p9,
  output logic        o_enable,
  output logic        o_frame_done,
  output logic        o_sof_err
`ifdef WIN_COORD_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  o_col
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] col, col_nxt, pos_col;
  logic [RW-1:0] row, row_nxt, pos_row;
  logic [23:0] lb0 [IMG_WIDTH];
  logic [23:0] lb1 [IMG_WIDTH];
  logic [23:0] up1, up2;
  logic [2:0][23:0] c0, c1;
  logic acc, emit, last, err;
  // A sof pixel is always position (0,0), whatever the counters say.
  always_comb begin
    acc       = i_valid && (state == ACTIVE || i_sof);
    pos_col   = i_sof ? '0 : col;
    pos_row   = i_sof ? '0 : row;
    emit      = acc && pos_row >= RW'(2) && pos_col >= CW'(2);
    last      = acc && pos_row == LAST_ROW && pos_col == LAST_COL;
    err       = acc && state == ACTIVE && i_sof && (col != '0 || row != '0);
    state_nxt = last ? IDLE : acc ? ACTIVE : state;
    col_nxt   = !acc ? col : (pos_col == LAST_COL) ? '0 : pos_col + 1'b1;
    row_nxt   = !acc ? row : last ? '0 : (pos_col == LAST_COL) ? pos_row + 1'b1 : pos_row;
  end
  assign up2 = lb1[pos_col];
  assign up1 = lb0[pos_col];
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end
  always_ff @(posedge iClk) begin
    if (acc) begin
      lb1[pos_col] <= up1;
      lb0[pos_col] <= i_pixel;
    end
  end
  // c0/c1 hold columns c-2/c-1 as {top, mid, bottom}; outputs take the shifted window.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      c0           <= '0;
      c1           <= '0;
      o_enable     <= 1'b0;
      o_frame_done <= 1'b0;
      o_sof_err    <= 1'b0;
      {o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8, o_p9} <= '0;
    end else begin
      o_enable     <= emit;
      o_frame_done <= last;
      o_sof_err    <= err;
      if (acc) begin
        c0 <= c1;
        c1 <= {up2, up1, i_pixel};
      end
      if (emit) begin
        {o_p1, o_p2, o_p3} <= {c0[2], c1[2], up2};
        {o_p4, o_p5, o_p6} <= {c0[1], c1[1], up1};
        {o_p7, o_p8, o_p9} <= {c0[0], c1[0], i_pixel};
      end
    end
  end
`ifdef WIN_COORD_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      o_row <= '0;
      o_col <= '0;
    end else if (emit) begin
      o_row <= pos_row - 1'b1;
      o_col <= pos_col - 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: random/directed stimulus checked against a 2-D image reference model.
module tb_window_gen_3x3;
  localparam int W = 5;
  localparam int H = 4;
  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic [23:0] i_pixel = '0;
  logic i_valid = 1'b0;
  logic i_sof = 1'b0;
  logic [23:0] o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8, o_p9;
  logic o_enable, o_frame_done, o_sof_err;
`ifdef WIN_COORD_EN
  logic [1:0] o_row;
  logic [2:0] o_col;
`endif
  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] img [H][W];
  logic [23:0] exp_p [9];
  bit m_active;
  int m_r, m_c, exp_row, exp_col;
  bit exp_en, exp_fd, exp_err;
  int en_cnt, fd_cnt, err_cnt, en0, fd0, err0;
  bit got_first;
  logic [23:0] first_p1, first_p5, first_p9, last_p1, last_p9;

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .iClk(iClk), .iRst(iRst), .i_pixel(i_pixel), .i_valid(i_valid), .i_sof(i_sof),
    .o_p1(o_p1), .o_p2(o_p2), .o_p3(o_p3), .o_p4(o_p4), .o_p5(o_p5),
    .o_p6(o_p6), .o_p7(o_p7), .o_p8(o_p8), .o_p9(o_p9),
    .o_enable(o_enable), .o_frame_done(o_frame_done), .o_sof_err(o_sof_err)
`ifdef WIN_COORD_EN
    , .o_row(o_row), .o_col(o_col)
`endif
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [215:0] got, input logic [215:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] pv(input int r, input int c);
    logic [7:0] b;
    b = 8'(r * 16 + c);
    return {b, b, b};
  endfunction

  function automatic logic [215:0] win_exp();
    logic [215:0] w;
    for (int i = 0; i < 9; i++) w[215 - 24 * i -: 24] = exp_p[i];
    return w;
  endfunction

  task automatic check_outputs(input string where);
    chk({where, "_enable"}, 216'(o_enable), 216'(exp_en));
    chk({where, "_frame_done"}, 216'(o_frame_done), 216'(exp_fd));
    chk({where, "_sof_err"}, 216'(o_sof_err), 216'(exp_err));
    chk({where, "_window"}, {o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8, o_p9}, win_exp());
`ifdef WIN_COORD_EN
    chk({where, "_row"}, 216'(o_row), 216'(2'(exp_row)));
    chk({where, "_col"}, 216'(o_col), 216'(3'(exp_col)));
`endif
  endtask

  task automatic step(input logic v, input logic s, input logic [23:0] p);
    i_valid = v;
    i_sof   = s;
    i_pixel = p;
    exp_en = 0;
    exp_fd = 0;
    exp_err = 0;
    if (v && (m_active || s)) begin
      if (s) begin
        exp_err  = m_active && (m_r != 0 || m_c != 0);
        m_r      = 0;
        m_c      = 0;
        m_active = 1;
      end
      img[m_r][m_c] = p;
      if (m_r >= 2 && m_c >= 2) begin
        exp_en = 1;
        for (int i = 0; i < 9; i++) exp_p[i] = img[m_r - 2 + i / 3][m_c - 2 + i % 3];
        exp_row = m_r - 1;
        exp_col = m_c - 1;
      end
      if (m_r == H - 1 && m_c == W - 1) begin
        exp_fd   = 1;
        m_active = 0;
        m_r      = 0;
        m_c      = 0;
      end else if (m_c == W - 1) begin
        m_c = 0;
        m_r++;
      end else m_c++;
    end
    @(posedge iClk);
    #1;
    check_outputs("step");
    if (o_enable) begin
      if (!got_first) {first_p1, first_p5, first_p9} = {o_p1, o_p5, o_p9};
      got_first = 1;
      last_p1 = o_p1;
      last_p9 = o_p9;
      en_cnt++;
    end
    fd_cnt  += int'(o_frame_done);
    err_cnt += int'(o_sof_err);
  endtask

  // Reset is applied between edges so its asynchronous effect is visible at once.
  task automatic do_reset();
    iRst = 1'b1;
    i_valid = 1'b0;
    i_sof = 1'b0;
    #1;
    m_active = 0;
    m_r = 0;
    m_c = 0;
    {exp_en, exp_fd, exp_err} = '0;
    exp_row = 0;
    exp_col = 0;
    for (int i = 0; i < 9; i++) exp_p[i] = '0;
    check_outputs("reset");
    @(posedge iClk);
    #1;
    iRst = 1'b0;
  endtask

  task automatic frame(input bit pat, input int gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, r == 0 && c == 0, pat ? pv(r, c) : 24'($urandom));
        if (gap == 1) step(1'b0, 1'($urandom), 24'($urandom));
        if (gap == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 24'($urandom));
      end
  endtask

  task automatic partial(input int n);
    for (int k = 0; k < n; k++) step(1'b1, k == 0, 24'($urandom));
  endtask

  task automatic mark();
    en0 = en_cnt;
    fd0 = fd_cnt;
    err0 = err_cnt;
    got_first = 0;
  endtask

  task automatic pattern_checks(input string t);
    chk({t, "_windows"}, 216'(en_cnt - en0), 216'(6));
    chk({t, "_frame_done_cnt"}, 216'(fd_cnt - fd0), 216'(1));
    chk({t, "_first_p1"}, 216'(first_p1), 216'(pv(0, 0)));
    chk({t, "_first_p5"}, 216'(first_p5), 216'(pv(1, 1)));
    chk({t, "_first_p9"}, 216'(first_p9), 216'(pv(2, 2)));
    chk({t, "_last_p1"}, 216'(last_p1), 216'(pv(1, 2)));
    chk({t, "_last_p9"}, 216'(last_p9), 216'(pv(3, 4)));
  endtask

  initial begin
    #2;
    do_reset();
    mark();
    frame(1'b1, 0);
    step(1'b0, 1'b0, '0);
    pattern_checks("t1");
    chk("t1_sof_err_cnt", 216'(err_cnt - err0), 216'(0));
    mark();
    frame(1'b1, 1);
    pattern_checks("t2");
    do_reset();
    mark();
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 24'($urandom));
    chk("t3_junk_windows", 216'(en_cnt - en0), 216'(0));
    frame(1'b1, 0);
    pattern_checks("t3");
    mark();
    partial(11);
    frame(1'b0, 0);
    chk("t4_sof_err_cnt", 216'(err_cnt - err0), 216'(1));
    chk("t4_windows", 216'(en_cnt - en0), 216'(6));
    chk("t4_frame_done_cnt", 216'(fd_cnt - fd0), 216'(1));
    mark();
    frame(1'b0, 0);
    frame(1'b0, 0);
    chk("t5_windows", 216'(en_cnt - en0), 216'(12));
    chk("t5_frame_done_cnt", 216'(fd_cnt - fd0), 216'(2));
    mark();
    frame(1'b0, 2);
    chk("t5b_windows", 216'(en_cnt - en0), 216'(6));
    partial(13);
    chk("t6_enable_before_reset", 216'(o_enable), 216'(1));
    do_reset();
    mark();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 24'($urandom));
    chk("t6_ignored_windows", 216'(en_cnt - en0), 216'(0));
    frame(1'b0, 2);
    chk("t6_windows", 216'(en_cnt - en0), 216'(6));
    chk("t6_frame_done_cnt", 216'(fd_cnt - fd0), 216'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
